// File: rtl/poly_dp_pkg.sv
// Shared constants for the polynomial-evaluation datapath: coefficient
// select codes and the expected Horner step count per evaluation.
package poly_dp_pkg;

    localparam logic [1:0] SEL_C0 = 2'b00;
    localparam logic [1:0] SEL_C1 = 2'b01;
    localparam logic [1:0] SEL_C2 = 2'b10;
    localparam logic [1:0] SEL_C3 = 2'b11;

    localparam int TERM_CNT_W = 3;

    typedef logic [TERM_CNT_W-1:0] term_cnt_t;

    localparam term_cnt_t EXPECTED_TERMS = 3'd4;
    localparam term_cnt_t TERM_CNT_MAX   = 3'd7;

endpackage

// File: rtl/horner_mac.sv
// Combinational Horner step: next_sum = sum*x_reg + coef.
// With POLY_EVAL_SAT_EN defined the result saturates to all-ones and flags overflow.
module horner_mac #(
    parameter int X_W   = 8,
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] sum,
    input  logic [X_W-1:0]   x_reg,
    input  logic [ACC_W-1:0] coef,
    output logic [ACC_W-1:0] next_sum,
    output logic             overflow
);

`ifdef POLY_EVAL_SAT_EN
    localparam int FULL_W = ACC_W + X_W + 1;

    logic [FULL_W-1:0] full_sum;

    // Extra headroom bit keeps the coefficient add from wrapping before the check.
    always_comb begin
        full_sum = FULL_W'(sum) * FULL_W'(x_reg) + FULL_W'(coef);
        overflow = |full_sum[FULL_W-1:ACC_W];
        next_sum = overflow ? '1 : full_sum[ACC_W-1:0];
    end
`else
    always_comb begin
        next_sum = sum * ACC_W'(x_reg) + coef;
        overflow = 1'b0;
    end
`endif

endmodule

// File: rtl/poly_eval_datapath.sv
// Horner datapath behind the 5-state polynomial controller: operand, accumulator,
// edge-qualified result register and sticky error flags. Optional saturation: POLY_EVAL_SAT_EN.
module poly_eval_datapath
    import poly_dp_pkg::*;
#(
    parameter int X_W   = 8,
    parameter int ACC_W = 24,
    parameter int COEF0 = 2,
    parameter int COEF1 = 4,
    parameter int COEF2 = 3,
    parameter int COEF3 = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [X_W-1:0]   x_in,
    input  logic             x_ld,
    input  logic             sum_ld,
    input  logic             sum_clr,
    input  logic [1:0]       mult_sel,
    input  logic             y_ld,
    output logic [ACC_W-1:0] y_out,
    output logic             y_valid,
    output logic [2:0]       term_cnt,
    output logic             proto_err,
    output logic             ovf
);

    logic [X_W-1:0]   x_reg_q, x_reg_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] y_out_q, y_out_d;
    logic             y_valid_q, y_valid_d;
    logic             y_ld_q, y_ld_d;
    term_cnt_t        term_cnt_q, term_cnt_d;
    logic             proto_err_q, proto_err_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] coef;
    logic [ACC_W-1:0] mac_next;
    logic             mac_ovf;
    logic             step;
    logic             y_rise;

    always_comb begin
        coef = ACC_W'(COEF0);
        case (mult_sel)
            SEL_C0:  coef = ACC_W'(COEF0);
            SEL_C1:  coef = ACC_W'(COEF1);
            SEL_C2:  coef = ACC_W'(COEF2);
            SEL_C3:  coef = ACC_W'(COEF3);
            default: coef = ACC_W'(COEF0);
        endcase
    end

    horner_mac #(
        .X_W   (X_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .sum      (sum_q),
        .x_reg    (x_reg_q),
        .coef     (coef),
        .next_sum (mac_next),
        .overflow (mac_ovf)
    );

    // The controller parks in s4 with y_ld high, so only its rising edge loads a result.
    always_comb begin
        step        = sum_ld & ~sum_clr;
        y_rise      = y_ld & ~y_ld_q;
        x_reg_d     = x_ld ? x_in : x_reg_q;
        sum_d       = sum_q;
        term_cnt_d  = term_cnt_q;
        if (sum_clr) begin
            sum_d      = '0;
            term_cnt_d = '0;
        end else if (sum_ld) begin
            sum_d = mac_next;
            if (term_cnt_q != TERM_CNT_MAX) begin
                term_cnt_d = term_cnt_q + 1'b1;
            end
        end
        y_ld_d      = y_ld;
        y_valid_d   = y_rise;
        y_out_d     = y_rise ? sum_q : y_out_q;
        proto_err_d = proto_err_q
                    | (sum_ld & sum_clr)
                    | (y_rise & (term_cnt_q != EXPECTED_TERMS))
                    | (x_ld & y_ld);
        ovf_d       = ovf_q | (step & mac_ovf);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg_q     <= '0;
            sum_q       <= '0;
            y_out_q     <= '0;
            y_valid_q   <= 1'b0;
            y_ld_q      <= 1'b0;
            term_cnt_q  <= '0;
            proto_err_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            x_reg_q     <= x_reg_d;
            sum_q       <= sum_d;
            y_out_q     <= y_out_d;
            y_valid_q   <= y_valid_d;
            y_ld_q      <= y_ld_d;
            term_cnt_q  <= term_cnt_d;
            proto_err_q <= proto_err_d;
            ovf_q       <= ovf_d;
        end
    end

    assign y_out     = y_out_q;
    assign y_valid   = y_valid_q;
    assign term_cnt  = term_cnt_q;
    assign proto_err = proto_err_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_poly_eval_datapath.sv
// Directed bench for poly_eval_datapath: a 24-bit and a 16-bit accumulator share
// stimulus; expectations for the 16-bit instance follow POLY_EVAL_SAT_EN.
module tb_poly_eval_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  x_in;
    logic        x_ld, sum_ld, sum_clr, y_ld;
    logic [1:0]  mult_sel;

    logic [23:0] y_out;
    logic        y_valid, proto_err, ovf;
    logic [2:0]  term_cnt;
    logic [15:0] y_out16;
    logic        y_valid16, proto_err16, ovf16;
    logic [2:0]  term_cnt16;

    int total = 0;
    int bad   = 0;
    int pulses;

    always #5 clk = ~clk;

    poly_eval_datapath #(.X_W(8), .ACC_W(24)) dut (
        .clk(clk), .reset(reset), .x_in(x_in), .x_ld(x_ld), .sum_ld(sum_ld),
        .sum_clr(sum_clr), .mult_sel(mult_sel), .y_ld(y_ld), .y_out(y_out),
        .y_valid(y_valid), .term_cnt(term_cnt), .proto_err(proto_err), .ovf(ovf)
    );

    poly_eval_datapath #(.X_W(8), .ACC_W(16)) dut16 (
        .clk(clk), .reset(reset), .x_in(x_in), .x_ld(x_ld), .sum_ld(sum_ld),
        .sum_clr(sum_clr), .mult_sel(mult_sel), .y_ld(y_ld), .y_out(y_out16),
        .y_valid(y_valid16), .term_cnt(term_cnt16), .proto_err(proto_err16), .ovf(ovf16)
    );

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        x_ld = 1'b0; sum_ld = 1'b0; sum_clr = 1'b0; y_ld = 1'b0; mult_sel = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_and_load(input logic [7:0] x);
        x_in = x; x_ld = 1'b1; sum_clr = 1'b1; sum_ld = 1'b0; y_ld = 1'b0;
        tick();
        x_ld = 1'b0; sum_clr = 1'b0;
    endtask

    task automatic horner_step(input logic [1:0] sel);
        sum_ld = 1'b1; mult_sel = sel;
        tick();
        sum_ld = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [7:0] x, input int n);
        logic [1:0] seq [4];
        seq = '{2'b11, 2'b00, 2'b10, 2'b01};
        clear_and_load(x);
        for (int i = 0; i < n; i++) horner_step(seq[i]);
    endtask

    task automatic pulse_y();
        y_ld = 1'b1;
        tick();
    endtask

    initial begin
        x_in = 8'd0;
        do_reset();
        $display("[TB] reset values");
        check_output("rst_y_out", 32'(y_out), 32'd0);
        check_output("rst_y_valid", 32'(y_valid), 32'd0);
        check_output("rst_term_cnt", 32'(term_cnt), 32'd0);
        check_output("rst_proto_err", 32'(proto_err), 32'd0);
        check_output("rst_ovf", 32'(ovf), 32'd0);

        $display("[TB] nominal x=2");
        apply_stimulus(8'd2, 4);
        check_output("nom_term_cnt", 32'(term_cnt), 32'd4);
        pulse_y();
        check_output("nom_y_out", 32'(y_out), 32'd26);
        check_output("nom_y_valid", 32'(y_valid), 32'd1);
        check_output("nom_proto_err", 32'(proto_err), 32'd0);
        check_output("nom_y_out16", 32'(y_out16), 32'd26);

        $display("[TB] held y_ld");
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (y_valid) pulses++;
        end
        check_output("held_extra_pulses", 32'(pulses), 32'd0);
        check_output("held_y_out", 32'(y_out), 32'd26);
        check_output("held_proto_err", 32'(proto_err), 32'd0);
        y_ld = 1'b0;
        tick();

        $display("[TB] x_ld on last step uses old x");
        clear_and_load(8'd2);
        horner_step(2'b11);
        horner_step(2'b00);
        horner_step(2'b10);
        sum_ld = 1'b1; mult_sel = 2'b01; x_ld = 1'b1; x_in = 8'd9;
        tick();
        sum_ld = 1'b0; x_ld = 1'b0;
        pulse_y();
        check_output("oldx_y_out", 32'(y_out), 32'd26);
        y_ld = 1'b0;
        tick();

        $display("[TB] x=255");
        apply_stimulus(8'd255, 4);
        pulse_y();
        check_output("x255_y_out", 32'(y_out), 32'd16712194);
        check_output("x255_ovf", 32'(ovf), 32'd0);
        check_output("x255_proto_err", 32'(proto_err), 32'd0);
        check_output("x255_term_cnt16", 32'(term_cnt16), 32'd4);
`ifdef POLY_EVAL_SAT_EN
        check_output("x255_y_out16", 32'(y_out16), 32'h0000FFFF);
        check_output("x255_ovf16", 32'(ovf16), 32'd1);
`else
        check_output("x255_y_out16", 32'(y_out16), 32'd514);
        check_output("x255_ovf16", 32'(ovf16), 32'd0);
`endif
        y_ld = 1'b0;
        tick();

        $display("[TB] y_ld with sum_clr captures pre-clear sum");
        apply_stimulus(8'd2, 4);
        y_ld = 1'b1; sum_clr = 1'b1;
        tick();
        sum_clr = 1'b0;
        check_output("preclr_y_out", 32'(y_out), 32'd26);
        check_output("preclr_y_valid", 32'(y_valid), 32'd1);
        check_output("preclr_term_cnt", 32'(term_cnt), 32'd0);
        check_output("preclr_proto_err", 32'(proto_err), 32'd0);
        y_ld = 1'b0;
        tick();

        $display("[TB] term_cnt saturation");
        clear_and_load(8'd1);
        for (int i = 0; i < 9; i++) horner_step(2'b00);
        check_output("sat_term_cnt", 32'(term_cnt), 32'd7);

        $display("[TB] reset during s2");
        clear_and_load(8'd3);
        horner_step(2'b11);
        horner_step(2'b00);
        sum_ld = 1'b1; mult_sel = 2'b10;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("midrst_y_out", 32'(y_out), 32'd0);
        check_output("midrst_term_cnt", 32'(term_cnt), 32'd0);
        check_output("midrst_y_valid", 32'(y_valid), 32'd0);
        check_output("midrst_ovf16", 32'(ovf16), 32'd0);
        sum_ld = 1'b0;
        tick();
        check_output("midrst_y_valid_hold", 32'(y_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(8'd3, 4);
        pulse_y();
        check_output("rerun_y_out", 32'(y_out), 32'd58);
        check_output("rerun_y_valid", 32'(y_valid), 32'd1);
        check_output("rerun_proto_err", 32'(proto_err), 32'd0);
        y_ld = 1'b0;
        tick();

        $display("[TB] early y_ld after 2 steps");
        apply_stimulus(8'd3, 2);
        pulse_y();
        check_output("early_y_out", 32'(y_out), 32'd5);
        check_output("early_proto_err", 32'(proto_err), 32'd1);
        y_ld = 1'b0;
        tick();
        tick();
        check_output("early_proto_sticky", 32'(proto_err), 32'd1);

        $display("[TB] sum_ld with sum_clr");
        do_reset();
        apply_stimulus(8'd2, 2);
        sum_ld = 1'b1; sum_clr = 1'b1; mult_sel = 2'b00;
        tick();
        sum_ld = 1'b0; sum_clr = 1'b0;
        check_output("both_term_cnt", 32'(term_cnt), 32'd0);
        check_output("both_proto_err", 32'(proto_err), 32'd1);
        horner_step(2'b11);
        horner_step(2'b00);
        horner_step(2'b10);
        horner_step(2'b01);
        pulse_y();
        check_output("both_sum_cleared", 32'(y_out), 32'd26);
        y_ld = 1'b0;
        repeat (5) tick();
        check_output("both_proto_sticky", 32'(proto_err), 32'd1);

        $display("[TB] x_ld with y_ld");
        do_reset();
        apply_stimulus(8'd2, 4);
        pulse_y();
        tick();
        check_output("xy_before", 32'(proto_err), 32'd0);
        x_ld = 1'b1; x_in = 8'd5;
        tick();
        x_ld = 1'b0;
        check_output("xy_proto_err", 32'(proto_err), 32'd1);
        y_ld = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
